// File: rtl/arbitro_balance_pkg.sv
// Shared constants, FSM encodings and result type for the ATM balance arbiter.
package arbitro_balance_pkg;

    localparam int N_CAJEROS = 4;
    localparam int N_CUENTAS = 16;
    localparam int MONTO_W   = 32;
    localparam int BAL_W     = 64;
    localparam int CTA_W     = 4;
    localparam int IDX_W     = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LEER = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Outcome of one transaction: exactly one flag set, valor is the balance to report.
    typedef struct packed {
        logic             ok;
        logic             insuf;
        logic             desb;
        logic [BAL_W-1:0] valor;
    } resultado_t;

    // One-hot to binary index; input is guaranteed one-hot by the picker.
    function automatic logic [IDX_W-1:0] onehot_a_idx(input logic [N_CAJEROS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CAJEROS; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbitro_balance_rr.sv
// Round-robin picker: first requester scanning upward from ptr+1, wrapping.
module rr_prioridad
    import arbitro_balance_pkg::*;
(
    input  logic [N_CAJEROS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [N_CAJEROS-1:0] gnt,
    output logic                 vld
);

    logic [IDX_W-1:0] idx;

    // Offsets 1..4 from ptr; offset 4 wraps back onto ptr itself, giving it lowest priority.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 1; i <= N_CAJEROS; i++) begin
            idx = ptr + IDX_W'(i);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_balance.sv
// Four-ATM arbiter over sixteen 64-bit account balances, one transaction in flight.
module arbitro_balance
    import arbitro_balance_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CAJEROS-1:0]         REQ,
    input  logic [N_CAJEROS-1:0]         TIPO_TRANS,
    input  logic [N_CAJEROS*MONTO_W-1:0] MONTO,
    input  logic [N_CAJEROS*CTA_W-1:0]   CUENTA,
    input  logic                         CARGA_STB,
    input  logic [CTA_W-1:0]             CARGA_CUENTA,
    input  logic [BAL_W-1:0]             CARGA_VALOR,
    output logic [N_CAJEROS-1:0]         GNT,
    output logic                         DONE,
    output logic                         BALANCE_ACTUALIZADO,
    output logic                         FONDOS_INSUFICIENTES,
    output logic                         DESBORDE,
    output logic [BAL_W-1:0]             BALANCE_OUT
);

    logic [1:0]           estado;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win;
    logic                 tipo_l;
    logic [MONTO_W-1:0]   monto_l;
    logic [CTA_W-1:0]     cuenta_l;
    logic [BAL_W-1:0]     bal_trab;
    resultado_t           res_p1;
    logic                 vld_p1;
    logic [BAL_W-1:0]     saldos [N_CUENTAS];

    logic [N_CAJEROS-1:0] rr_gnt;
    logic                 rr_vld;
    logic [IDX_W-1:0]     rr_idx;

    // Deposit rejects on carry out of 64 bits; withdrawal rejects when amount exceeds balance.
    function automatic resultado_t calcular(input logic tipo,
                                            input logic [MONTO_W-1:0] monto,
                                            input logic [BAL_W-1:0] bal);
        resultado_t       r;
        logic [BAL_W:0]   suma;
        logic [BAL_W-1:0] monto_ext;
        r         = '0;
        monto_ext = {{(BAL_W-MONTO_W){1'b0}}, monto};
        suma      = {1'b0, bal} + {1'b0, monto_ext};
        if (!tipo) begin
            if (suma[BAL_W]) begin
                r.desb  = 1'b1;
                r.valor = bal;
            end else begin
                r.ok    = 1'b1;
                r.valor = suma[BAL_W-1:0];
            end
        end else if (monto_ext <= bal) begin
            r.ok    = 1'b1;
            r.valor = bal - monto_ext;
        end else begin
            r.insuf = 1'b1;
            r.valor = bal;
        end
        return r;
    endfunction

    rr_prioridad u_rr (
        .req (REQ),
        .ptr (ptr),
        .gnt (rr_gnt),
        .vld (rr_vld)
    );

    assign rr_idx = onehot_a_idx(rr_gnt);

    // Transaction FSM; CALC spends two cycles so the 64-bit add is registered before the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado               <= ST_IDLE;
            ptr                  <= IDX_W'(N_CAJEROS - 1);
            win                  <= '0;
            tipo_l               <= 1'b0;
            monto_l              <= '0;
            cuenta_l             <= '0;
            bal_trab             <= '0;
            res_p1               <= '0;
            vld_p1               <= 1'b0;
            GNT                  <= '0;
            DONE                 <= 1'b0;
            BALANCE_ACTUALIZADO  <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            DESBORDE             <= 1'b0;
            BALANCE_OUT          <= '0;
            for (int i = 0; i < N_CUENTAS; i++) saldos[i] <= '0;
        end else begin
            case (estado)
                ST_IDLE: begin
                    if (CARGA_STB) begin
                        saldos[CARGA_CUENTA] <= CARGA_VALOR;
                    end else if (rr_vld) begin
                        win      <= rr_idx;
                        ptr      <= rr_idx;
                        tipo_l   <= TIPO_TRANS[rr_idx];
                        monto_l  <= MONTO[rr_idx*MONTO_W +: MONTO_W];
                        cuenta_l <= CUENTA[rr_idx*CTA_W +: CTA_W];
                        GNT      <= rr_gnt;
                        estado   <= ST_LEER;
                    end
                end
                // ---- stage p0: fetch balance of the latched account ----
                ST_LEER: begin
                    bal_trab <= saldos[cuenta_l];
                    estado   <= ST_CALC;
                end
                // ---- stage p1: arithmetic result, then commit with DONE ----
                ST_CALC: begin
                    if (!vld_p1) begin
                        res_p1 <= calcular(tipo_l, monto_l, bal_trab);
                        vld_p1 <= 1'b1;
                    end else begin
                        vld_p1 <= 1'b0;
                        if (res_p1.ok) saldos[cuenta_l] <= res_p1.valor;
                        DONE                 <= 1'b1;
                        BALANCE_ACTUALIZADO  <= res_p1.ok;
                        FONDOS_INSUFICIENTES <= res_p1.insuf;
                        DESBORDE             <= res_p1.desb;
                        BALANCE_OUT          <= res_p1.valor;
                        estado               <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!REQ[win]) begin
                        GNT                  <= '0;
                        DONE                 <= 1'b0;
                        BALANCE_ACTUALIZADO  <= 1'b0;
                        FONDOS_INSUFICIENTES <= 1'b0;
                        DESBORDE             <= 1'b0;
                        BALANCE_OUT          <= '0;
                        estado               <= ST_IDLE;
                    end
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_balance.sv
// Directed bench for arbitro_balance: loads, deposits, withdrawals, overflow, arbitration, reset abort.
module tb_arbitro_balance;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   REQ;
    logic [3:0]   TIPO_TRANS;
    logic [127:0] MONTO;
    logic [15:0]  CUENTA;
    logic         CARGA_STB;
    logic [3:0]   CARGA_CUENTA;
    logic [63:0]  CARGA_VALOR;
    logic [3:0]   GNT;
    logic         DONE;
    logic         BALANCE_ACTUALIZADO;
    logic         FONDOS_INSUFICIENTES;
    logic         DESBORDE;
    logic [63:0]  BALANCE_OUT;

    int n_chk  = 0;
    int n_ok   = 0;
    int n_fail = 0;

    arbitro_balance dut (
        .clk                  (clk),
        .rst                  (rst),
        .REQ                  (REQ),
        .TIPO_TRANS           (TIPO_TRANS),
        .MONTO                (MONTO),
        .CUENTA               (CUENTA),
        .CARGA_STB            (CARGA_STB),
        .CARGA_CUENTA         (CARGA_CUENTA),
        .CARGA_VALOR          (CARGA_VALOR),
        .GNT                  (GNT),
        .DONE                 (DONE),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
        .DESBORDE             (DESBORDE),
        .BALANCE_OUT          (BALANCE_OUT)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_ok++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] flags();
        return {61'd0, BALANCE_ACTUALIZADO, FONDOS_INSUFICIENTES, DESBORDE};
    endfunction

    task automatic pulso_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cargar(input logic [3:0] cta, input logic [63:0] val);
        CARGA_STB    = 1'b1;
        CARGA_CUENTA = cta;
        CARGA_VALOR  = val;
        tick();
        CARGA_STB    = 1'b0;
    endtask

    // One full transaction for a single requester; operands scrambled after grant.
    task automatic trans(input string tag, input int c, input logic t,
                         input logic [31:0] m, input logic [3:0] a,
                         input logic [63:0] eb, input logic [2:0] ef);
        logic [3:0] g;
        g = 4'b0001 << c;
        TIPO_TRANS[c]       = t;
        MONTO[32*c +: 32]   = m;
        CUENTA[4*c +: 4]    = a;
        REQ[c]              = 1'b1;
        tick();
        chk({tag, "_gnt"}, {60'd0, GNT}, {60'd0, g});
        TIPO_TRANS[c]       = ~t;
        MONTO[32*c +: 32]   = 32'hFFFF_FFFF;
        CUENTA[4*c +: 4]    = a ^ 4'hF;
        tick();
        tick();
        chk({tag, "_done_early"}, {63'd0, DONE}, 64'd0);
        tick();
        chk({tag, "_done"}, {63'd0, DONE}, 64'd1);
        chk({tag, "_flags"}, flags(), {61'd0, ef});
        chk({tag, "_bal"}, BALANCE_OUT, eb);
        REQ[c] = 1'b0;
        tick();
        chk({tag, "_clr"}, {59'd0, GNT, DONE}, 64'd0);
    endtask

    initial begin
        rst          = 1'b0;
        REQ          = '0;
        TIPO_TRANS   = '0;
        MONTO        = '0;
        CUENTA       = '0;
        CARGA_STB    = 1'b0;
        CARGA_CUENTA = '0;
        CARGA_VALOR  = '0;
        #1;
        pulso_reset();

        chk("rst_gnt",   {60'd0, GNT}, 64'd0);
        chk("rst_done",  {63'd0, DONE}, 64'd0);
        chk("rst_flags", flags(), 64'd0);
        chk("rst_bal",   BALANCE_OUT, 64'd0);

        // Deposit into a preloaded account.
        cargar(4'd2, 64'd1000);
        trans("dep", 1, 1'b0, 32'd500, 4'd2, 64'd1500, 3'b100);

        // Withdrawal rejected, then exact withdrawal to zero.
        cargar(4'd5, 64'd100);
        trans("ret_insuf", 0, 1'b1, 32'd150, 4'd5, 64'd100, 3'b010);
        trans("ret_exact", 0, 1'b1, 32'd100, 4'd5, 64'd0, 3'b100);

        // Overflow boundary.
        cargar(4'd7, 64'hFFFF_FFFF_FFFF_FFF6);
        trans("ovf",     2, 1'b0, 32'd10, 4'd7, 64'hFFFF_FFFF_FFFF_FFF6, 3'b001);
        trans("ovf_max", 2, 1'b0, 32'd9,  4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100);

        // Load beats a same-cycle request; load during LEER is ignored.
        TIPO_TRANS[0] = 1'b0;
        MONTO[31:0]   = 32'd8;
        CUENTA[3:0]   = 4'd3;
        REQ           = 4'b0001;
        CARGA_STB     = 1'b1;
        CARGA_CUENTA  = 4'd3;
        CARGA_VALOR   = 64'd42;
        tick();
        chk("carga_gana_gnt", {60'd0, GNT}, 64'd0);
        CARGA_STB = 1'b0;
        tick();
        chk("carga_luego_gnt", {60'd0, GNT}, 64'd1);
        CARGA_STB    = 1'b1;
        CARGA_CUENTA = 4'd9;
        CARGA_VALOR  = 64'd999;
        tick();
        CARGA_STB = 1'b0;
        tick();
        tick();
        chk("carga_done",  {63'd0, DONE}, 64'd1);
        chk("carga_bal",   BALANCE_OUT, 64'd50);
        chk("carga_flags", flags(), 64'd4);
        REQ = '0;
        tick();
        trans("carga_leer_ign", 1, 1'b0, 32'd0, 4'd9, 64'd0, 3'b100);
        trans("carga_cta3",     1, 1'b0, 32'd0, 4'd3, 64'd50, 3'b100);

        // Reset in CALC of a withdrawal aborts it and wipes balances; also beats CARGA_STB.
        cargar(4'd4, 64'd200);
        TIPO_TRANS[3]  = 1'b1;
        MONTO[127:96]  = 32'd50;
        CUENTA[15:12]  = 4'd4;
        REQ            = 4'b1000;
        tick();
        chk("abort_gnt", {60'd0, GNT}, 64'd8);
        tick();
        rst          = 1'b1;
        CARGA_STB    = 1'b1;
        CARGA_CUENTA = 4'd6;
        CARGA_VALOR  = 64'd77;
        tick();
        chk("abort_out", {59'd0, GNT, DONE}, 64'd0);
        chk("abort_flags", flags(), 64'd0);
        chk("abort_bal", BALANCE_OUT, 64'd0);
        rst       = 1'b0;
        CARGA_STB = 1'b0;
        REQ       = '0;
        tick();
        trans("abort_cta4", 0, 1'b0, 32'd0, 4'd4, 64'd0, 3'b100);
        trans("abort_cta6", 0, 1'b0, 32'd0, 4'd6, 64'd0, 3'b100);
        trans("abort_cta2", 0, 1'b0, 32'd0, 4'd2, 64'd0, 3'b100);
        trans("abort_cta7", 0, 1'b0, 32'd0, 4'd7, 64'd0, 3'b100);

        // All four requesting: round-robin from cajero 0, each deposits 1 into its own account.
        pulso_reset();
        TIPO_TRANS = 4'b0000;
        MONTO      = {32'd1, 32'd1, 32'd1, 32'd1};
        CUENTA     = {4'd3, 4'd2, 4'd1, 4'd0};
        REQ        = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0]  g;
            logic [63:0] eb;
            g  = 4'b0001 << (k % 4);
            eb = (k == 4) ? 64'd2 : 64'd1;
            tick();
            chk($sformatf("rr%0d_gnt", k), {60'd0, GNT}, {60'd0, g});
            tick();
            tick();
            tick();
            chk($sformatf("rr%0d_done", k), {63'd0, DONE}, 64'd1);
            chk($sformatf("rr%0d_bal", k), BALANCE_OUT, eb);
            tick();
            chk($sformatf("rr%0d_hold", k), {59'd0, GNT, DONE}, {59'd0, g, 1'b1});
            REQ[k % 4] = 1'b0;
            tick();
            chk($sformatf("rr%0d_clr", k), {59'd0, GNT, DONE}, 64'd0);
            REQ[k % 4] = 1'b1;
        end
        REQ = '0;
        tick();

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/arbitro_balance.md
ARBITRO_BALANCE -- requirements
Module: arbitro_balance

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 REQ  in  4  per-ATM request, bit i = cajero i; level, held until DONE seen.
REQ-004 TIPO_TRANS  in  4  bit i: 0 deposit, 1 withdrawal.
REQ-005 MONTO  in  128  cajero i amount in MONTO[32i+31:32i], unsigned.
REQ-006 CUENTA  in  16  cajero i account index in CUENTA[4i+3:4i], 16 accounts.
REQ-007 CARGA_STB  in  1  one-cycle strobe to load a balance.
REQ-008 CARGA_CUENTA  in  4 / CARGA_VALOR  in  64  load target and value.
REQ-009 GNT  out  4  one-hot grant, zero when idle.
REQ-010 DONE  out  1  transaction complete, level, held until granted REQ drops.
REQ-011 BALANCE_ACTUALIZADO  out  1  valid with DONE; balance written.
REQ-012 FONDOS_INSUFICIENTES  out  1  valid with DONE; withdrawal rejected.
REQ-013 DESBORDE  out  1  valid with DONE; deposit rejected on 64-bit overflow.
REQ-014 BALANCE_OUT  out  64  valid with DONE; post-transaction balance, or unchanged balance if rejected.

Function
REQ-015 Block SHALL hold 16 x 64-bit balance registers, one transaction in flight.
REQ-016 States SHALL be IDLE, LEER, CALC, RESP.
REQ-017 IDLE: if CARGA_STB, write CARGA_VALOR to CARGA_CUENTA, stay IDLE; loads win over requests that cycle.
REQ-018 IDLE, no CARGA_STB, REQ!=0: latch winner, its TIPO/MONTO/CUENTA; set GNT[winner]; go LEER.
REQ-019 Winner SHALL be first set REQ bit scanning up from ptr+1 modulo 4 (round-robin); ptr <= winner on grant.
REQ-020 LEER: read selected balance into working register; go CALC.
REQ-021 CALC deposit: 65-bit sum; carry out -> DESBORDE=1, no write; else write sum, BALANCE_ACTUALIZADO=1.
REQ-022 CALC withdrawal: MONTO<=balance -> write balance-MONTO, BALANCE_ACTUALIZADO=1; MONTO==balance yields 0; else FONDOS_INSUFICIENTES=1, no write.
REQ-023 CALC -> RESP: DONE=1 and result flags registered same edge; write lands same edge.
REQ-024 Latency: REQ sampled at edge N -> GNT at N, DONE high after edge N+3.
REQ-025 RESP: hold DONE, flags, BALANCE_OUT, GNT until REQ[winner]==0; then clear all, go IDLE.
REQ-026 Latched operands SHALL be used; input changes after grant have no effect.
REQ-027 CARGA_STB outside IDLE SHALL be ignored (no write).
REQ-028 Exactly one of BALANCE_ACTUALIZADO/FONDOS_INSUFICIENTES/DESBORDE SHALL be 1 while DONE=1; all 0 otherwise.
REQ-029 Non-winning requests SHALL wait, no loss; each waits at most 3 transactions.

Reset
REQ-030 rst SHALL force IDLE, all outputs 0, all 16 balances 0, ptr=3 (cajero 0 first priority), latched operands 0.
REQ-031 rst mid-transaction SHALL abort it with no balance write; rst overrides CARGA_STB.

Structure
REQ-032 Shared package SHALL hold state encodings, N_CAJEROS=4, N_CUENTAS=16, MONTO_W=32, BAL_W=64.
REQ-033 Round-robin picker SHALL be sub-module rr_prioridad (combinational: REQ, ptr -> one-hot winner, valid).

Verification
REQ-034 Load acct 2=1000; cajero 1 deposit 500 acct 2 -> GNT=0010, DONE 3 cycles later, BALANCE_OUT=1500, BALANCE_ACTUALIZADO=1.
REQ-035 Acct 5=100; cajero 0 withdraw 150 -> FONDOS_INSUFICIENTES=1, BALANCE_OUT=100; withdraw 100 -> BALANCE_OUT=0, ok.
REQ-036 Acct 7=2^64-10; deposit 10 -> DESBORDE=1, balance unchanged; deposit 9 -> 2^64-1.
REQ-037 REQ=1111 held continuously after reset -> grant order 0,1,2,3,0; each DONE clears only after that REQ drops.
REQ-038 CARGA_STB with REQ=0001 in IDLE -> load first, grant next cycle; CARGA_STB during LEER -> no write.
REQ-039 rst asserted in CALC of withdrawal 50 from 200 -> IDLE, outputs 0, all balances 0.
